ctrl_sequencer: RTL
===================

// Module: ctrl_sequencer
// PURPOSE
//  Multi-cycle control unit for the 32-bit cs147sec05 processor data path.
//  - Fetches, decodes and sequences every instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK.
//  - Drives the 32-bit data-path control word and the memory read/write strobes, with a ready handshake.
// PARAMETERS
//  CTRL_W   32   control word width (`CTRL_WIDTH_INDEX_LIMIT+1)
//  DATA_W   32   instruction/data width (`DATA_INDEX_LIMIT+1)
// PORTS
//  CLK          in   1   clock, rising edge
//  RST          in   1   reset; asynchronous, active-low
//  INSTRUCTION  in   32  memory read data (raw, pre-IR)
//  ZERO         in   1   ALU zero flag
//  MEM_READY    in   1   memory accepts write / read data valid this cycle
//  CTRL         out  32  data-path control word (bit map below)
//  MEM_READ     out  1   memory read strobe
//  MEM_WRITE    out  1   memory write strobe
//  HALT         out  1   illegal-opcode trap (only with CTRL_ILLEGAL_TRAP_EN; else tied 0)
// BEHAVIOUR
//  CTRL map: 0 pc_load, 1 pc_sel_1, 2 pc_sel_2, 3 pc_sel_3, 4 ir_load, 5 r1_sel_1, 6 reg_r, 7 reg_w,
//   8 sp_load, 9 op1_sel_1, 10-13 op2_sel_1..4, 19:14 alu_oprn, 20-21 ma_sel_1..2, 22 md_sel_1,
//   23-25 wd_sel_1..3, 26-28 wa_sel_1..3, 31:29 reserved (0).
//  ALU oprn: add=1 sub=2 mul=3 shr=4 shl=5 and=6 or=7 nor=8 slt=9.
//  Reset (RST=0, async): state=RST_ST; CTRL, MEM_READ, MEM_WRITE, HALT and the internal instruction latch = 0.
//   - First rising edge after release: RST_ST -> FETCH.
//   - RST asserted mid-instruction aborts it; no partial pc/reg/sp/mem write survives the reset edge.
//  FSM: RST_ST -> FETCH -> DECODE -> EXECUTE -> MEMORY -> WRITEBACK -> FETCH. Five cycles per instruction when
//   MEM_READY=1.
//  FETCH: ma_sel_2=1 (ADDR=PC), MEM_READ=1.
//   - MEM_READY=0: hold FETCH, ir_load=0.
//   - MEM_READY=1: ir_load=1, internal latch <= INSTRUCTION, advance.
//  DECODE: reg_r=1; r1_sel_1=1 for push (reads R0); opcode/funct classified from internal latch.
//  EXECUTE: op1/op2/alu_oprn per class; held constant through WRITEBACK.
//   - Immediates: andi/ori zero-extend; addi/muli/slti sign-extend.
//   - sll/srl use shamt; beq/bne sub R1,R2.
//   - push: sp-1; pop: sp+1 (op1_sel_1=1, op2=1).
//  MEMORY: only lw/sw/push/pop strobe; others pass through in one cycle.
//   - lw/sw: addr=ALU.
//   - push: addr=SP, md_sel_1=1, MEM_WRITE=1.
//   - pop: addr=ALU (SP+1), MEM_READ=1.
//   - MEM_READY=0 holds MEMORY with strobe high; exactly one strobe cycle is accepted (MEM_READY=1).
//  WRITEBACK: pc_load=1 always.
//   - PC next: default pc_sel_3=1, pc_sel_2=0, pc_sel_1=1 (PC+1).
//   - beq (ZERO=1) / bne (ZERO=0): pc_sel_2=1. ZERO is sampled in WRITEBACK; ALU inputs are held.
//   - jr: pc_sel_1=0. jmp/jal: pc_sel_3=0.
//   - reg_w for R-type (except jr), I-type ALU ops, lui (wd_sel_2=1), lw (wd_sel_1=1), pop (wa=0), jal (wa=31, wd_sel_3=0).
//   - sp_load for push/pop.
//  Strobes: MEM_READ and MEM_WRITE are never high together; both are 0 outside FETCH/MEMORY.
//  Outputs are Moore: decoded from state + latched instruction, glitch-free at the clock edge.
// CONFIGURATION
//  CTRL_ILLEGAL_TRAP_EN defined: unknown opcode/funct in DECODE -> HALT_ST.
//   - HALT=1, CTRL=0, no strobes; only reset exits.
//  CTRL_ILLEGAL_TRAP_EN undefined: unknown opcode executes as NOP (PC+1, no writes); HALT=0.
// STRUCTURE
//  Shared package/include ctrl_definition.v:
//   - state encodings, opcode/funct constants, ALU oprn codes, CTRL bit-index macros.
//  Sub-module ctrl_decoder (combinational): latched instruction -> instruction class + legal flag.
// TESTING
//  1. Reset release, PC=0x1000, mem returns addi r1,r0,5: 5 cycles; WB reg_w=1, wa_sel_3=1/wa_sel_1=1, oprn=1, pc->0x1001.
//  2. beq r1,r2,+4 with ZERO=1: WB pc_sel_2=1, pc_load=1. Same with ZERO=0: pc_sel_2=0 (PC+1).
//  3. lw with MEM_READY=0 for 3 cycles in MEMORY: MEM_READ held; state holds; WB wd_sel_1=1 after ready.
//  4. push: EXE oprn=2 op1_sel_1=1; MEM MEM_WRITE=1 ma_sel_1=1 md_sel_1=1; WB sp_load=1 reg_w=0.
//  5. jal 0x0000ABC: WB pc_sel_3=0, wa=31, wd_sel_3=0, reg_w=1. jr r31: pc_sel_1=0.
//  6. Opcode 0x3F: with _EN, HALT=1 and CTRL=0 forever. Without: NOP, pc+1. RST low in MEMORY: all outputs 0 at once.

Source files
------------

// File: rtl/ctrl_sequencer_pkg.sv
// Shared definitions for the cs147sec05 multi-cycle control sequencer:
// state encodings, opcode/funct constants, ALU operation codes, control-word
// bit positions, the decoded-instruction struct and the helper functions that
// turn (state, instruction class) into the control word and memory strobes.
package ctrl_sequencer_pkg;

  localparam int CTRL_BITS = 32;

  typedef enum logic [2:0] {
    RST_ST    = 3'd0,
    FETCH     = 3'd1,
    DECODE    = 3'd2,
    EXECUTE   = 3'd3,
    MEMORY    = 3'd4,
    WRITEBACK = 3'd5,
    HALT_ST   = 3'd6
  } state_t;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00, OP_ADDI = 6'h08, OP_MULI = 6'h1d,
                         OP_ANDI  = 6'h0c, OP_ORI  = 6'h0d, OP_LUI  = 6'h0f,
                         OP_SLTI  = 6'h0a, OP_BEQ  = 6'h04, OP_BNE  = 6'h05,
                         OP_LW    = 6'h23, OP_SW   = 6'h2b, OP_JMP  = 6'h02,
                         OP_JAL   = 6'h03, OP_PUSH = 6'h1b, OP_POP  = 6'h1c;
  // R-type funct codes
  localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_MUL = 6'h2c,
                         FN_SRL = 6'h02, FN_SLL = 6'h01, FN_AND = 6'h24,
                         FN_OR  = 6'h25, FN_NOR = 6'h27, FN_SLT = 6'h2a,
                         FN_JR  = 6'h08;
  // ALU operation codes
  localparam logic [5:0] ALU_NONE = 6'd0, ALU_ADD = 6'd1, ALU_SUB = 6'd2,
                         ALU_MUL  = 6'd3, ALU_SHR = 6'd4, ALU_SHL = 6'd5,
                         ALU_AND  = 6'd6, ALU_OR  = 6'd7, ALU_NOR = 6'd8,
                         ALU_SLT  = 6'd9;

  // Control word bit positions
  localparam int PC_LOAD = 0,  PC_SEL_1 = 1,  PC_SEL_2 = 2,  PC_SEL_3 = 3,
                 IR_LOAD = 4,  R1_SEL_1 = 5,  REG_R    = 6,  REG_W    = 7,
                 SP_LOAD = 8,  OP1_SEL_1 = 9, OP2_SEL_1 = 10, OP2_SEL_2 = 11,
                 OP2_SEL_3 = 12, OP2_SEL_4 = 13, ALU_LO = 14, ALU_HI = 19,
                 MA_SEL_1 = 20, MA_SEL_2 = 21, MD_SEL_1 = 22,
                 WD_SEL_1 = 23, WD_SEL_2 = 24, WD_SEL_3 = 25,
                 WA_SEL_1 = 26, WA_SEL_2 = 27, WA_SEL_3 = 28;

  typedef enum logic [3:0] {
    CL_NOP, CL_RALU, CL_SHIFT, CL_JR, CL_IZ, CL_IS, CL_LUI, CL_BEQ,
    CL_BNE, CL_LW, CL_SW, CL_JMP, CL_JAL, CL_PUSH, CL_POP
  } iclass_t;

  typedef struct packed {
    iclass_t    cls;
    logic [5:0] oprn;
    logic       legal;
  } dec_t;

  function automatic logic is_mem(input dec_t d);
    return d.cls inside {CL_LW, CL_SW, CL_PUSH, CL_POP};
  endfunction

  function automatic state_t next_state(input state_t st, input dec_t d,
                                        input logic mem_ready, input logic trap_en);
    case (st)
      RST_ST:    return FETCH;
      FETCH:     return mem_ready ? DECODE : FETCH;
      DECODE:    return (trap_en && !d.legal) ? HALT_ST : EXECUTE;
      EXECUTE:   return MEMORY;
      MEMORY:    return (is_mem(d) && !mem_ready) ? MEMORY : WRITEBACK;
      WRITEBACK: return FETCH;
      HALT_ST:   return HALT_ST;
      default:   return RST_ST;
    endcase
  endfunction

  // Control word for a state. ir_load is not produced here: it follows
  // MEM_READY inside FETCH and is merged in by the top.
  function automatic logic [CTRL_BITS-1:0] ctrl_word(input state_t st, input dec_t d,
                                                     input logic zero);
    logic [CTRL_BITS-1:0] w;
    logic in_exe;
    w      = '0;
    in_exe = st inside {EXECUTE, MEMORY, WRITEBACK};
    if (st == FETCH) w[MA_SEL_2] = 1'b1;
    // Register read and ALU operand selection stay stable from DECODE/EXECUTE
    // through WRITEBACK so ZERO and the ALU result hold for the later stages.
    if (st == DECODE || in_exe) begin
      w[REG_R]    = 1'b1;
      w[R1_SEL_1] = (d.cls == CL_PUSH);
    end
    if (in_exe) begin
      w[ALU_HI:ALU_LO] = d.oprn;
      case (d.cls)
        CL_RALU, CL_BEQ, CL_BNE: w[OP2_SEL_4] = 1'b1;
        CL_SHIFT: begin w[OP2_SEL_3] = 1'b1; w[OP2_SEL_1] = 1'b1; end
        CL_IS, CL_LW, CL_SW: w[OP2_SEL_2] = 1'b1;
        CL_PUSH, CL_POP: begin w[OP1_SEL_1] = 1'b1; w[OP2_SEL_3] = 1'b1; end
        default: ;
      endcase
    end
    if (st == MEMORY && d.cls == CL_PUSH) begin
      w[MA_SEL_1] = 1'b1;
      w[MD_SEL_1] = 1'b1;
    end
    if (st == WRITEBACK) begin
      w[PC_LOAD]  = 1'b1;
      w[PC_SEL_1] = (d.cls != CL_JR);
      w[PC_SEL_3] = !(d.cls inside {CL_JMP, CL_JAL});
      w[PC_SEL_2] = (d.cls == CL_BEQ && zero) || (d.cls == CL_BNE && !zero);
      w[SP_LOAD]  = d.cls inside {CL_PUSH, CL_POP};
      case (d.cls)
        CL_RALU, CL_SHIFT: begin w[REG_W] = 1'b1; w[WD_SEL_3] = 1'b1; w[WA_SEL_3] = 1'b1; end
        CL_IZ, CL_IS: begin
          w[REG_W] = 1'b1; w[WD_SEL_3] = 1'b1; w[WA_SEL_3] = 1'b1; w[WA_SEL_1] = 1'b1;
        end
        CL_LUI: begin
          w[REG_W] = 1'b1; w[WD_SEL_3] = 1'b1; w[WD_SEL_2] = 1'b1;
          w[WA_SEL_3] = 1'b1; w[WA_SEL_1] = 1'b1;
        end
        CL_LW: begin
          w[REG_W] = 1'b1; w[WD_SEL_3] = 1'b1; w[WD_SEL_1] = 1'b1;
          w[WA_SEL_3] = 1'b1; w[WA_SEL_1] = 1'b1;
        end
        // pop writes memory data into R0 (wa mux chain selects 0)
        CL_POP: begin w[REG_W] = 1'b1; w[WD_SEL_3] = 1'b1; w[WD_SEL_1] = 1'b1; end
        // jal writes PC+1 into R31
        CL_JAL: begin w[REG_W] = 1'b1; w[WA_SEL_2] = 1'b1; end
        default: ;
      endcase
    end
    return w;
  endfunction

  function automatic logic rd_strobe(input state_t st, input dec_t d);
    return (st == FETCH) || (st == MEMORY && d.cls inside {CL_LW, CL_POP});
  endfunction

  function automatic logic wr_strobe(input state_t st, input dec_t d);
    return (st == MEMORY && d.cls inside {CL_SW, CL_PUSH});
  endfunction

endpackage

// File: rtl/ctrl_sequencer_decoder.sv
// Combinational instruction classifier.
// Ports: opcode/funct (instruction fields) -> dec (class, ALU oprn, legal).
// Unknown opcode/funct decodes as CL_NOP with legal=0.
module ctrl_sequencer_decoder import ctrl_sequencer_pkg::*; (
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output dec_t       dec
);

  function automatic dec_t mk(input iclass_t c, input logic [5:0] o);
    return '{cls: c, oprn: o, legal: 1'b1};
  endfunction

  always_comb begin
    dec = mk(CL_NOP, ALU_NONE);
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  dec = mk(CL_RALU, ALU_ADD);
          FN_SUB:  dec = mk(CL_RALU, ALU_SUB);
          FN_MUL:  dec = mk(CL_RALU, ALU_MUL);
          FN_AND:  dec = mk(CL_RALU, ALU_AND);
          FN_OR:   dec = mk(CL_RALU, ALU_OR);
          FN_NOR:  dec = mk(CL_RALU, ALU_NOR);
          FN_SLT:  dec = mk(CL_RALU, ALU_SLT);
          FN_SRL:  dec = mk(CL_SHIFT, ALU_SHR);
          FN_SLL:  dec = mk(CL_SHIFT, ALU_SHL);
          FN_JR:   dec = mk(CL_JR, ALU_NONE);
          default: dec.legal = 1'b0;
        endcase
      end
      OP_ADDI: dec = mk(CL_IS, ALU_ADD);
      OP_MULI: dec = mk(CL_IS, ALU_MUL);
      OP_SLTI: dec = mk(CL_IS, ALU_SLT);
      OP_ANDI: dec = mk(CL_IZ, ALU_AND);
      OP_ORI:  dec = mk(CL_IZ, ALU_OR);
      OP_LUI:  dec = mk(CL_LUI, ALU_NONE);
      OP_BEQ:  dec = mk(CL_BEQ, ALU_SUB);
      OP_BNE:  dec = mk(CL_BNE, ALU_SUB);
      OP_LW:   dec = mk(CL_LW, ALU_ADD);
      OP_SW:   dec = mk(CL_SW, ALU_ADD);
      OP_JMP:  dec = mk(CL_JMP, ALU_NONE);
      OP_JAL:  dec = mk(CL_JAL, ALU_NONE);
      OP_PUSH: dec = mk(CL_PUSH, ALU_SUB);
      OP_POP:  dec = mk(CL_POP, ALU_ADD);
      default: dec.legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// Multi-cycle control unit for the cs147sec05 data path.
// Sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK and drives the control word
// and memory strobes, stalling on MEM_READY in FETCH and in MEMORY.
// Ports: CLK, RST (async active-low), INSTRUCTION (raw memory data), ZERO (ALU
//   flag), MEM_READY (handshake) -> CTRL (control word), MEM_READ, MEM_WRITE,
//   HALT (illegal-instruction trap).
// Build option: CTRL_ILLEGAL_TRAP_EN -- when defined, an unknown opcode/funct
//   seen in DECODE parks the sequencer in HALT_ST (HALT=1) until reset; when
//   undefined it runs as a NOP and HALT is tied 0.
module ctrl_sequencer import ctrl_sequencer_pkg::*; #(
  parameter int CTRL_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] INSTRUCTION,
  input  logic              ZERO,
  input  logic              MEM_READY,
  output logic [CTRL_W-1:0] CTRL,
  output logic              MEM_READ,
  output logic              MEM_WRITE,
  output logic              HALT
);

`ifdef CTRL_ILLEGAL_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
`else
  localparam logic TRAP_EN = 1'b0;
`endif

  state_t            state_q, state_nxt;
  logic [5:0]        op_q, fn_q, op_nxt, fn_nxt;
  logic [CTRL_W-1:0] ctrl_q;
  logic              rd_q, wr_q, fetch_hit, ir_load;
  dec_t              dec;
  logic              unused_instr;

  // Only opcode and funct steer the sequencer; register/immediate fields go
  // straight to the data path.
  assign unused_instr = ^INSTRUCTION[DATA_W-7:6];

  assign fetch_hit = (state_q == FETCH) && MEM_READY;
  // Decode the word being latched so the registered outputs for DECODE
  // already see the new instruction.
  assign op_nxt    = fetch_hit ? INSTRUCTION[DATA_W-1 -: 6] : op_q;
  assign fn_nxt    = fetch_hit ? INSTRUCTION[5:0] : fn_q;

  ctrl_sequencer_decoder u_dec (
    .opcode (op_nxt),
    .funct  (fn_nxt),
    .dec    (dec)
  );

  assign state_nxt = next_state(state_q, dec, MEM_READY, TRAP_EN);

  // Outputs are registered from the next state so they change only at the
  // clock edge; an async reset clears them immediately.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= RST_ST;
      op_q    <= '0;
      fn_q    <= '0;
      ctrl_q  <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_nxt;
      op_q    <= op_nxt;
      fn_q    <= fn_nxt;
      ctrl_q  <= CTRL_W'(ctrl_word(state_nxt, dec, ZERO));
      rd_q    <= rd_strobe(state_nxt, dec);
      wr_q    <= wr_strobe(state_nxt, dec);
    end
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic halt_q;
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) halt_q <= 1'b0;
    else      halt_q <= (state_nxt == HALT_ST);
  end
  assign HALT = halt_q;
`else
  assign HALT = 1'b0;
`endif

  // ir_load tracks the fetch handshake within the FETCH cycle itself, so it
  // is gated off the registered state rather than precomputed.
  assign ir_load   = fetch_hit;
  assign CTRL      = ctrl_q | (CTRL_W'(ir_load) << IR_LOAD);
  assign MEM_READ  = rd_q;
  assign MEM_WRITE = wr_q;

endmodule
